// File: rtl/input_debouncer_pkg.sv
// Shared types and sizing helpers for the input debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

    // Counter must hold values 0..stable_cycles.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Raw input and debounced outputs of one debouncer channel.
interface input_debouncer_if;
    logic x_in;
    logic x_db;
    logic settling;

    modport master (output x_in, input x_db, input settling);
    modport slave  (input x_in, output x_db, output settling);
endinterface

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages_r;

    // Shift register; the first stage absorbs metastability.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages_r <= {SYNC_STAGES{1'b0}};
        end else begin
            stages_r <= {stages_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages_r[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises and debounces one bouncy input into a clean level; a new level
// is accepted only after STABLE_CYCLES consecutive synchronised samples.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input_debouncer_if.slave  db
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync_s;
    db_state_t     state_r;
    db_state_t     state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          x_db_r;
    logic          settling_r;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (db.x_in),
        .q     (sync_s)
    );

    // Next-state and counter; a reversion always beats qualification.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            LOW: begin
                if (sync_s) begin
                    state_s = WAIT_HIGH;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = LOW;
                end
            end
            WAIT_HIGH: begin
                if (!sync_s) begin
                    state_s = LOW;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = HIGH;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync_s) begin
                    state_s = WAIT_LOW;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = HIGH;
                end
            end
            WAIT_LOW: begin
                if (sync_s) begin
                    state_s = HIGH;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = LOW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = LOW;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and outputs registered from the next state so x_db
    // changes on the same edge that enters HIGH or LOW.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= LOW;
            cnt_r      <= CNT_ZERO;
            x_db_r     <= 1'b0;
            settling_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            x_db_r     <= (state_s == HIGH) || (state_s == WAIT_LOW);
            settling_r <= (state_s == WAIT_HIGH) || (state_s == WAIT_LOW);
        end
    end

    assign db.x_db     = x_db_r;
    assign db.settling = settling_r;

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed bench for input_debouncer against a window-based model.
module tb_input_debouncer;

    localparam int SYNC   = 2;
    localparam int STABLE = 16;
    localparam int HMAX   = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    input_debouncer_if dif ();

    input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .db    (dif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Model: per-edge history; x_db flips once the trailing STABLE synchronised
    // samples since reset all differ from it.
    bit xin_h [HMAX];
    bit rst_h [HMAX];
    int n = 0;
    bit m_db  = 1'b0;
    bit m_set = 1'b0;
    int run;

    function automatic bit s_seen(input int j);
        for (int i = 1; i <= SYNC; i++)
            if (j - i < 0 || !rst_h[j-i]) return 1'b0;
        return xin_h[j-SYNC];
    endfunction

    always @(posedge clk) begin
        if (n < HMAX) begin
            xin_h[n] = dif.x_in;
            rst_h[n] = rst_n;
            if (!rst_n) begin
                m_db  = 1'b0;
                m_set = 1'b0;
            end else begin
                run = 0;
                for (int j = n; j >= 0; j--) begin
                    if (!rst_h[j] || s_seen(j) == m_db || run >= STABLE) break;
                    run++;
                end
                if (run >= STABLE) begin
                    m_db  = ~m_db;
                    m_set = 1'b0;
                end else begin
                    m_set = (run > 0);
                end
            end
            n++;
        end
    end

    bit chk_en      = 1'b0;
    bit prev_db     = 1'b0;
    int edges       = 0;
    int set_run     = 0;
    int max_set_run = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("x_db", dif.x_db, m_db);
            check("settling", dif.settling, m_set);
            if (dif.x_db != prev_db) edges++;
            prev_db = dif.x_db;
            if (dif.settling) set_run++;
            else set_run = 0;
            if (set_run > max_set_run) max_set_run = set_run;
        end
    end

    task automatic tick(input bit x, input bit r);
        @(negedge clk);
        dif.x_in = x;
        rst_n    = r;
    endtask

    task automatic hold(input bit x, input int cyc);
        repeat (cyc) tick(x, 1'b1);
    endtask

    // Waits after release (rst_n already 1) and returns edges from first sample to rise.
    task automatic measure_rise(input string tag);
        int lat;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (dif.x_db && lat < 0) lat = i - 1;
        end
        check(tag, lat, SYNC + STABLE - 1);
    endtask

    initial begin
        int v, len;
        dif.x_in = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_x_db", dif.x_db, 0);
        check("reset_settling", dif.settling, 0);
        rst_n = 1'b1;
        measure_rise("latency_after_reset");

        // Toggle every clock: nothing accepted, settling single-cycle pulses.
        hold(1'b0, 30);
        max_set_run = 0;
        for (int i = 0; i < 20; i++) tick((i % 2) == 0, 1'b1);
        hold(1'b0, 30);
        check("toggle_db_low", dif.x_db, 0);
        check("toggle_settle_run", max_set_run, 1);

        // From HIGH: 15 low cycles rejected (reversion on qualification cycle).
        hold(1'b1, 30);
        hold(1'b0, 15);
        hold(1'b1, 30);
        check("glitch15_db", dif.x_db, 1);
        check("glitch15_settling", dif.settling, 0);
        check("glitch15_state", int'(dut.state_r), 2);
        hold(1'b0, 16);
        hold(1'b1, 5);
        @(negedge clk);
        check("glitch16_db", dif.x_db, 0);
        hold(1'b0, 30);
        // From LOW: 15 high cycles rejected.
        hold(1'b1, 15);
        hold(1'b0, 30);
        check("pulse15_db", dif.x_db, 0);
        check("pulse15_state", int'(dut.state_r), 0);

        // Clean alternation with a downstream transition count.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        hold(1'b0, 5);
        edges = 0;
        for (int r = 0; r < 5; r++) begin
            hold(1'b0, 40);
            hold(1'b1, 40);
        end
        hold(1'b0, 40);
        check("edge_pulses", edges, 10);

        // Reset five cycles into WAIT_HIGH.
        hold(1'b1, SYNC + 5);
        tick(1'b1, 1'b0);
        check("wait_before_reset", dif.settling, 1);
        @(negedge clk);
        check("midwait_state", int'(dut.state_r), 0);
        check("midwait_cnt", int'(dut.cnt_r), 0);
        check("midwait_settling", dif.settling, 0);
        check("midwait_db", dif.x_db, 0);
        rst_n = 1'b1;
        measure_rise("latency_after_midwait_reset");

        // Random bursts with occasional resets.
        for (int b = 0; b < 60; b++) begin
            if ($urandom_range(0, 14) == 0) tick(1'b0, 1'b0);
            v   = $urandom_range(0, 1);
            len = $urandom_range(1, 24);
            hold(v[0], len);
        end
        hold(1'b0, 25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
